// File: rtl/seq_divider_32.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_32
// Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int         CNT_W  = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;

    // The working dividend doubles as the quotient shift register: each step
    // shifts a dividend bit out of the top and a quotient bit in at the bottom.
    assign w_shifted  = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial    = w_shifted - {1'b0, r_dvs};
    assign w_rem_next = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_dvd       <= dividend;
                        r_dvs       <= divisor;
                        r_rem       <= '0;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(WIDTH - 1);
                            busy    <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        quotient  <= w_dvd_next;
                        remainder <= w_rem_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider_32
// Purpose  : Directed and random checks of seq_divider_32 against a / and % model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
    endtask

    // Wait for done and compare against plain arithmetic; optionally pulse an
    // extra start (9 / 9) inj cycles into the run, which must be ignored.
    task automatic wait_check(input logic [31:0] a, input logic [31:0] b, input int inj);
        int lat;
        int busy_cnt;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_z;
        exp_z = (b == 0);
        exp_q = exp_z ? 32'hFFFF_FFFF : a / b;
        exp_r = exp_z ? a : a % b;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) begin
                busy_cnt++;
                chk("quotient_hidden_while_busy", quotient, 32'd0);
            end
            if (lat == inj) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd9;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        chk("done_seen",    {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("latency",      lat,      exp_z ? 32'd0 : 32'd32);
        chk("busy_cycles",  busy_cnt, exp_z ? 32'd0 : 32'd32);
        chk("quotient",     quotient, exp_q);
        chk("remainder",    remainder, exp_r);
        chk("div_by_zero",  {31'd0, div_by_zero}, {31'd0, exp_z});
    endtask

    // One cycle after done: pulse ends, results hold.
    task automatic post_check(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_q;
        exp_q = (b == 0) ? 32'hFFFF_FFFF : a / b;
        step();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after",     {31'd0, busy}, 32'd0);
        chk("quotient_held",  quotient, exp_q);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #12;
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_done",      {31'd0, done}, 32'd0);
        chk("rst_quotient",  quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
        step();
        rst_n = 1'b1;

        // Directed cases
        issue(32'd100, 32'd7);          wait_check(32'd100, 32'd7, -1);          post_check(32'd100, 32'd7);
        issue(32'hFFFF_FFFF, 32'd1);    wait_check(32'hFFFF_FFFF, 32'd1, -1);    post_check(32'hFFFF_FFFF, 32'd1);
        issue(32'd3, 32'd10);           wait_check(32'd3, 32'd10, -1);           post_check(32'd3, 32'd10);
        issue(32'd5, 32'd0);            wait_check(32'd5, 32'd0, -1);            post_check(32'd5, 32'd0);
        issue(32'd1000, 32'd3);         wait_check(32'd1000, 32'd3, 9);          post_check(32'd1000, 32'd3);

        // Back-to-back request during the DONE cycle
        issue(32'd50, 32'd6);
        wait_check(32'd50, 32'd6, -1);
        issue(32'd81, 32'd4);
        chk("b2b_busy_rise", {31'd0, busy}, 32'd1);
        chk("b2b_done_drop", {31'd0, done}, 32'd0);
        wait_check(32'd81, 32'd4, -1);
        post_check(32'd81, 32'd4);

        // Asynchronous reset in the middle of a run
        issue(32'd77, 32'd5);
        repeat (14) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      {31'd0, busy}, 32'd0);
        chk("mid_rst_done",      {31'd0, done}, 32'd0);
        chk("mid_rst_quotient",  quotient, 32'd0);
        chk("mid_rst_remainder", remainder, 32'd0);
        repeat (3) begin
            step();
            chk("rst_held_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("post_rst_idle_done", {31'd0, done}, 32'd0);
        issue(32'd77, 32'd5);
        wait_check(32'd77, 32'd5, -1);
        post_check(32'd77, 32'd5);

        // Random operands, including small and zero divisors
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = $urandom;
                1:       rb = $urandom_range(0, 3);
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom_range(1, 1000);
            endcase
            if (i % 3 == 0) ra = ra >> $urandom_range(0, 31);
            issue(ra, rb);
            wait_check(ra, rb, -1);
            if (i % 5 == 0) begin
                ra = $urandom;
                rb = $urandom_range(0, 65535);
                issue(ra, rb);
                wait_check(ra, rb, -1);
            end
            post_check(ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider_32.md
# seq_divider_32

Multi-cycle 32-bit unsigned restoring divider for the execute stage. It performs the inverse of the ripple add/subtract path: it removes the divisor by repeated shift-and-subtract, one quotient bit per clock. The execute stage hands it operands with a start pulse and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32: operand and result width. The iteration count equals `WIDTH`.

- `clk`  in  1  clock; rising-edge active
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  request. Sampled only when the block is idle or done.
- `dividend`  in  WIDTH  numerator. Sampled on an accepted `start`.
- `divisor`  in  WIDTH  denominator. Sampled on an accepted `start`.
- `busy`  out  1  high while an iteration is in progress
- `done`  out  1  one-cycle pulse; results are valid from this cycle on
- `quotient`  out  WIDTH  result; held until the next accepted `start`
- `remainder`  out  WIDTH  result; held until the next accepted `start`
- `div_by_zero`  out  1  status of the last operation; held with the results

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with `start`=1: accept the request.
  - Latch the operands.
  - Clear `quotient`, `remainder` and `div_by_zero`.
  - If `divisor`≠0, go to RUN with the iteration counter at WIDTH-1.
  - If `divisor`=0, go to DONE directly.
- IDLE or DONE with `start`=0:
  - DONE moves to IDLE after one cycle.
  - IDLE stays in IDLE.
  - Results hold in both cases.
- RUN, one step per cycle:
  - Shift the {partial remainder, working dividend} pair left by 1.
  - Form the trial difference: partial remainder minus divisor, at WIDTH+1 bits.
  - If the trial is non-negative (MSB=0): the partial remainder takes the difference and the new quotient LSB is 1.
  - Otherwise: the partial remainder is kept and the quotient LSB is 0.
  - The counter decrements. The step taken with counter=0 is the last; then go to DONE.
- Divide by zero:
  - `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
  - No RUN cycles are spent.
- Arithmetic is unsigned only. The trial subtraction uses WIDTH+1 bits so the borrow is unambiguous. Signed handling belongs to the caller.
- Invariant on completion with `div_by_zero`=0: dividend = quotient×divisor + remainder, and remainder < divisor.
- `start` while in RUN is ignored: no restart and no operand capture.
- `start` during the DONE cycle is accepted as a back-to-back request. `done` still pulses in that cycle, for the finishing operation.
- `quotient` and `remainder` change only on completion or on an accepted `start`. Intermediate values stay internal.

## Timing
- Reset (`rst_n`=0), effective immediately and independent of `clk`:
  - State goes to IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - The counter and internal registers clear.
- Reset mid-RUN abandons the operation. No `done` is produced.
- Leaving reset: the first edge with `rst_n`=1 may accept `start`.
- Normal divide, with the accepting edge called E0:
  - `busy`=1 from after E0 through E32.
  - 32 RUN edges, E1 to E32. Results are registered at E32.
  - After E32: `busy`=0 and `done`=1 for one cycle.
  - Latency is 32 cycles from the start edge to `done`.
- Divide by zero: `done`=1 in the cycle after E0, and `busy` never asserts.
- `busy` and `done` are never high together.
- Outputs are registered only. There are no combinational paths from inputs to outputs.
- Throughput: one divide per 33 cycles when `start` is asserted in each DONE cycle.

## Test plan
- 100 ÷ 7:
  - `busy` high for exactly 32 cycles.
  - `done` pulses once.
  - `quotient`=14, `remainder`=2, `div_by_zero`=0.
- 0xFFFFFFFF ÷ 1 → `quotient`=0xFFFFFFFF, `remainder`=0. Then 3 ÷ 10 → `quotient`=0, `remainder`=3.
- 5 ÷ 0:
  - `done` the cycle after `start`, with `busy` never high.
  - `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1.
- Start 1000 ÷ 3, then pulse `start` with 9 ÷ 9 at cycle 10:
  - The second request is ignored.
  - Result is `quotient`=333, `remainder`=1 at cycle 32.
- Start 50 ÷ 6, hold `start` high with 81 ÷ 4 in the DONE cycle:
  - `done` shows 8 r 2.
  - `busy` rises on the next cycle.
  - 32 cycles later `done` shows 20 r 1.
- Assert `rst_n`=0 at cycle 15 of 77 ÷ 5:
  - All outputs go to 0 asynchronously, with no `done`.
  - After release, 77 ÷ 5 completes normally → `quotient`=15, `remainder`=2.
